// File: rtl/arb_muxn_pkg.sv
// Shared arbitration constants and the select-width helper used by arb_muxn
// and its priority picker.
package arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int sel_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/arb_muxn_rr_pick.sv
// Rotating-base priority picker: the first requester found searching upward
// from base (wrapping mod N) wins; a zero base gives plain lowest-index priority.
module rr_pick #(
    parameter int N = 4,
    localparam int SELW = arb_pkg::sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] base,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] idx,
    output logic            any
);

    int cand_s;

    // Walk the N candidates in priority order and keep the first requester.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        cand_s = 0;
        for (int k = 0; k < N; k++) begin
            cand_s = (int'(base) + k) % N;
            if (!any && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                idx         = SELW'(cand_s);
                any         = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/arb_muxn.sv
// N-input arbitrating multiplexer feeding a one-entry registered valid/ready
// output stage; fixed-priority or round-robin selection chosen by MODE.
module arb_muxn #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int SELW = arb_pkg::sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_src,
    input  logic               out_ready
);

    import arb_pkg::*;

    logic [SELW-1:0] ptr_r;
    logic [N-1:0]    gnt_s;
    logic [SELW-1:0] idx_s;
    logic            any_s;
    logic            can_load_s;
    logic            xfer_s;
    logic [SELW-1:0] next_ptr_s;

    // ptr_r stays zero in fixed-priority mode, so the picker degenerates to lowest-index-wins.
    rr_pick #(.N(N)) u_pick (
        .req  (in_valid),
        .base (ptr_r),
        .gnt  (gnt_s),
        .idx  (idx_s),
        .any  (any_s)
    );

    // Accept gating: a grant is only offered when the output register has room.
    always_comb begin
        can_load_s = !out_valid || out_ready;
        xfer_s     = any_s && can_load_s && !rst;
        if (rst) begin
            in_ready = '0;
        end else begin
            in_ready = gnt_s & {N{can_load_s}};
        end
        if (idx_s == SELW'(N - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = idx_s + SELW'(1);
        end
    end

    // Output register: load on transfer, drop valid when drained, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (xfer_s) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(idx_s)*WIDTH +: WIDTH];
            out_src   <= idx_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= out_data;
            out_src   <= out_src;
        end else begin
            out_valid <= out_valid;
            out_data  <= out_data;
            out_src   <= out_src;
        end
    end

    // Round-robin pointer: the channel after the last winner gets top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (xfer_s && (MODE == ARB_RR)) begin
            ptr_r <= next_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: tb/tb_arb_muxn.sv
// Self-checking bench: fixed-priority and round-robin instances share stimulus
// and are compared against a queue-free behavioural model of the arbitration rules.
module tb_arb_muxn;

    localparam int W = 32;
    localparam int NC = 4;

    logic            clk;
    logic            rst;
    logic [NC-1:0]   in_valid;
    logic [NC*W-1:0] in_data;
    logic            out_ready;

    logic [NC-1:0] rdy_fp, rdy_rr;
    logic          ov_fp, ov_rr;
    logic [W-1:0]  od_fp, od_rr;
    logic [1:0]    os_fp, os_rr;

    int checks = 0;
    int failures = 0;

    // Model state, index 0 = fixed priority, 1 = round robin
    logic       m_valid [2];
    logic [W-1:0] m_data [2];
    int         m_src [2];
    int         m_ptr [2];

    arb_muxn #(.WIDTH(W), .N(NC), .MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_fp), .out_valid(ov_fp), .out_data(od_fp), .out_src(os_fp),
        .out_ready(out_ready));

    arb_muxn #(.WIDTH(W), .N(NC), .MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_src(os_rr),
        .out_ready(out_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input int m, input logic [NC-1:0] v);
        int b;
        b = (m == 1) ? m_ptr[1] : 0;
        for (int k = 0; k < NC; k++) begin
            if (v[(b + k) % NC]) return (b + k) % NC;
        end
        return -1;
    endfunction

    function automatic logic [NC-1:0] exp_ready(input int m);
        logic [NC-1:0] r;
        int p;
        r = '0;
        p = pick(m, in_valid);
        if (!rst && !(m_valid[m] && !out_ready) && p >= 0) r[p] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_valid[m] <= 1'b0;
                m_data[m]  <= '0;
                m_src[m]   <= 0;
                m_ptr[m]   <= 0;
            end else if ((!m_valid[m] || out_ready) && pick(m, in_valid) >= 0) begin
                m_valid[m] <= 1'b1;
                m_data[m]  <= in_data[pick(m, in_valid)*W +: W];
                m_src[m]   <= pick(m, in_valid);
                if (m == 1) m_ptr[m] <= (pick(m, in_valid) + 1) % NC;
            end else if (out_ready) begin
                m_valid[m] <= 1'b0;
            end
        end
    end

    task automatic rand_data();
        in_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        rand_data();
        @(negedge clk);
        @(negedge clk);
        checks++; if (rdy_fp !== 4'b0000) begin failures++; $display("FAIL reset_rdy_fp got=%b exp=0000", rdy_fp); end
        checks++; if (rdy_rr !== 4'b0000) begin failures++; $display("FAIL reset_rdy_rr got=%b exp=0000", rdy_rr); end
        checks++; if (ov_fp !== 1'b0 || ov_rr !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b/%b exp=0/0", ov_fp, ov_rr); end
        checks++; if (od_fp !== 32'h0 || od_rr !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0", od_fp, od_rr); end
        checks++; if (os_fp !== 2'd0 || os_rr !== 2'd0) begin failures++; $display("FAIL reset_src got=%0d/%0d exp=0", os_fp, os_rr); end
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        logic [W-1:0] want;
        do_reset();
        in_valid = 4'b1010;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            want = in_data[1*W +: W];
            #1;
            checks++; if (rdy_fp !== 4'b0010) begin failures++; $display("FAIL fixed_rdy cyc=%0d got=%b exp=0010", i, rdy_fp); end
            @(negedge clk);
            checks++; if (ov_fp !== 1'b1 || os_fp !== 2'd1 || od_fp !== want) begin
                failures++; $display("FAIL fixed_out cyc=%0d got v=%b src=%0d d=%h exp v=1 src=1 d=%h", i, ov_fp, os_fp, od_fp, want);
            end
        end
    endtask

    task automatic test_rr_all();
        int seq [5] = '{0, 1, 2, 3, 0};
        do_reset();
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            @(negedge clk);
            checks++; if (ov_rr !== 1'b1 || int'(os_rr) != seq[i] || od_rr !== m_data[1]) begin
                failures++; $display("FAIL rr_seq cyc=%0d got v=%b src=%0d d=%h exp v=1 src=%0d d=%h", i, ov_rr, os_rr, od_rr, seq[i], m_data[1]);
            end
            checks++; if (os_fp !== 2'd0) begin failures++; $display("FAIL rr_fp_src cyc=%0d got=%0d exp=0", i, os_fp); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        logic [W-1:0] want;
        do_reset();
        in_valid = 4'b0001;
        out_ready = 1'b1;
        rand_data();
        held = in_data[0 +: W];
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            #1;
            checks++; if (rdy_fp !== 4'b0000 || rdy_rr !== 4'b0000) begin
                failures++; $display("FAIL bp_rdy cyc=%0d got=%b/%b exp=0000", i, rdy_fp, rdy_rr);
            end
            @(negedge clk);
            checks++; if (ov_fp !== 1'b1 || od_fp !== held || os_fp !== 2'd0) begin
                failures++; $display("FAIL bp_hold cyc=%0d got v=%b d=%h src=%0d exp v=1 d=%h src=0", i, ov_fp, od_fp, os_fp, held);
            end
        end
        out_ready = 1'b1;
        rand_data();
        want = in_data[0 +: W];
        #1;
        checks++; if (rdy_fp !== 4'b0001) begin failures++; $display("FAIL bp_release_rdy got=%b exp=0001", rdy_fp); end
        @(negedge clk);
        checks++; if (ov_fp !== 1'b1 || od_fp !== want) begin
            failures++; $display("FAIL bp_reload got v=%b d=%h exp v=1 d=%h", ov_fp, od_fp, want);
        end
    endtask

    task automatic test_wrap();
        logic [NC-1:0] vs [4] = '{4'b0100, 4'b0100, 4'b1000, 4'b1111};
        int exp_src [4] = '{2, 2, 3, 0};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = vs[i];
            rand_data();
            @(negedge clk);
            checks++; if (ov_rr !== 1'b1 || int'(os_rr) != exp_src[i]) begin
                failures++; $display("FAIL wrap cyc=%0d got v=%b src=%0d exp v=1 src=%0d", i, ov_rr, os_rr, exp_src[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 4'b1111;
        out_ready = 1'b1;
        rand_data();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (rdy_fp !== 4'b0000 || rdy_rr !== 4'b0000) begin
            failures++; $display("FAIL midrst_rdy got=%b/%b exp=0000", rdy_fp, rdy_rr);
        end
        @(negedge clk);
        checks++; if (ov_fp !== 1'b0 || ov_rr !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b/%b exp=0", ov_fp, ov_rr); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ov_rr !== 1'b1 || os_rr !== 2'd0) begin failures++; $display("FAIL midrst_first got v=%b src=%0d exp v=1 src=0", ov_rr, os_rr); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid = NC'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            #1;
            checks++; if (rdy_fp !== exp_ready(0) || rdy_rr !== exp_ready(1)) begin
                failures++; $display("FAIL rand_rdy cyc=%0d got=%b/%b exp=%b/%b", i, rdy_fp, rdy_rr, exp_ready(0), exp_ready(1));
            end
            @(negedge clk);
            checks++; if (ov_fp !== m_valid[0] || od_fp !== m_data[0] || int'(os_fp) != m_src[0]) begin
                failures++; $display("FAIL rand_fp cyc=%0d got v=%b d=%h src=%0d exp v=%b d=%h src=%0d", i, ov_fp, od_fp, os_fp, m_valid[0], m_data[0], m_src[0]);
            end
            checks++; if (ov_rr !== m_valid[1] || od_rr !== m_data[1] || int'(os_rr) != m_src[1]) begin
                failures++; $display("FAIL rand_rr cyc=%0d got v=%b d=%h src=%0d exp v=%b d=%h src=%0d", i, ov_rr, od_rr, os_rr, m_valid[1], m_data[1], m_src[1]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_fixed();
        test_rr_all();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
